// File: rtl/pc_gen.sv
// Program-counter generator: sequential fetch, jump/branch redirects, trap entry/return, double-fault halt.
// Optional macro PC_C_EXT_EN enables 16-bit instruction increments and 2-byte target alignment.
module pc_gen #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_VEC = '0,
  parameter logic [XLEN-1:0]  TRAP_VEC  = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            stall_i,
  input  logic            valid_i,
  input  logic [1:0]      jmp_op_i,
  input  logic            cmp_i,
  input  logic            fault_i,
  input  logic [XLEN-1:0] next_addr_i,
  input  logic [XLEN-1:0] wb_pc_i,
  input  logic            ilen16_i,
  output logic [XLEN-1:0] addr_o,
  output logic            flush_o,
  output logic            trap_o,
  output logic [XLEN-1:0] epc_o,
  output logic [1:0]      cause_o,
  output logic            halt_o
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRAP = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_FAULT  = 2'd1;
  localparam logic [1:0] CAUSE_ALIGN  = 2'd2;
  localparam logic [1:0] CAUSE_ILLRET = 2'd3;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [1:0]      cause_q, cause_d;
  logic            flush_q, flush_d;
  logic            trap_q, trap_d;
  logic            halt_q, halt_d;

  logic [XLEN-1:0] inc;
  logic            misaligned;
  logic            taken;
  logic            take_trap;
  logic [1:0]      trap_cause;

`ifdef PC_C_EXT_EN
  assign inc        = ilen16_i ? XLEN'(2) : XLEN'(4);
  assign misaligned = next_addr_i[0];
`else
  logic unused_ilen16;
  assign unused_ilen16 = ilen16_i;
  assign inc           = XLEN'(4);
  assign misaligned    = |next_addr_i[1:0];
`endif

  assign taken = valid_i && ((jmp_op_i == 2'd1) || ((jmp_op_i == 2'd2) && cmp_i));

  // Trap request decode; jmp_op 3 is only legal while a handler is active.
  always_comb begin
    take_trap  = 1'b0;
    trap_cause = 2'd0;
    if (valid_i && fault_i) begin
      take_trap  = 1'b1;
      trap_cause = CAUSE_FAULT;
    end else if (valid_i && (jmp_op_i == 2'd3)) begin
      take_trap  = (state_q != ST_TRAP);
      trap_cause = CAUSE_ILLRET;
    end else if (taken && misaligned) begin
      take_trap  = 1'b1;
      trap_cause = CAUSE_ALIGN;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    halt_d  = halt_q;
    trap_d  = 1'b0;
    // Sticky flush drops only once fetch accepts (stall low).
    flush_d = flush_q && stall_i;

    if (state_q == ST_HALT) begin
      flush_d = 1'b0;
    end else if (take_trap) begin
      addr_d = TRAP_VEC;
      if (state_q == ST_TRAP) begin
        halt_d  = 1'b1;
        state_d = ST_HALT;
        flush_d = 1'b0;
      end else begin
        epc_d   = wb_pc_i;
        cause_d = trap_cause;
        trap_d  = 1'b1;
        state_d = ST_TRAP;
        flush_d = 1'b1;
      end
    end else if (valid_i && (jmp_op_i == 2'd3)) begin
      addr_d  = epc_q;
      state_d = ST_RUN;
      flush_d = 1'b1;
    end else if (taken) begin
      addr_d  = next_addr_i;
      flush_d = 1'b1;
    end else if (!stall_i) begin
      addr_d = addr_q + inc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_RUN;
      addr_q  <= RESET_VEC;
      epc_q   <= '0;
      cause_q <= 2'd0;
      flush_q <= 1'b0;
      trap_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      flush_q <= flush_d;
      trap_q  <= trap_d;
      halt_q  <= halt_d;
    end
  end

  assign addr_o  = addr_q;
  assign flush_o = flush_q;
  assign trap_o  = trap_q;
  assign epc_o   = epc_q;
  assign cause_o = cause_q;
  assign halt_o  = halt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed test-plan sequence plus randomized traffic against a behavioural model.
module tb_pc_gen;

  localparam int unsigned  XLEN = 32;
  localparam logic [31:0]  RV   = 32'h0000_0000;
  localparam logic [31:0]  TV   = 32'h0000_0200;

  logic        clk = 1'b0;
  logic        rst_n, stall, valid, cmp, fault, ilen16;
  logic [1:0]  jmp_op;
  logic [31:0] next_addr, wb_pc;
  logic [31:0] addr, epc;
  logic        flush, trap, halt;
  logic [1:0]  cause;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: mode 0 normal, 1 inside handler, 2 stopped.
  int          m_mode;
  logic [31:0] m_addr, m_epc;
  logic [1:0]  m_cause;
  logic        m_flush, m_trap, m_halt;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(XLEN), .RESET_VEC(RV), .TRAP_VEC(TV)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .stall_i(stall), .valid_i(valid),
    .jmp_op_i(jmp_op), .cmp_i(cmp), .fault_i(fault), .next_addr_i(next_addr),
    .wb_pc_i(wb_pc), .ilen16_i(ilen16), .addr_o(addr), .flush_o(flush),
    .trap_o(trap), .epc_o(epc), .cause_o(cause), .halt_o(halt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int step_size();
`ifdef PC_C_EXT_EN
    return ilen16 ? 2 : 4;
`else
    return 4;
`endif
  endfunction

  function automatic bit bad_target(input logic [31:0] a);
`ifdef PC_C_EXT_EN
    return (a % 2) != 0;
`else
    return (a % 4) != 0;
`endif
  endfunction

  task automatic model_step();
    int kind; // 0 plain, 1 trap, 2 return, 3 jump
    logic [1:0] why;
    bit redirect;
    if (!rst_n) begin
      m_mode = 0; m_addr = RV; m_epc = 0; m_cause = 0;
      m_flush = 0; m_trap = 0; m_halt = 0;
      return;
    end
    m_trap = 0;
    if (m_mode == 2) begin
      m_flush = 0;
      return;
    end
    redirect = valid && (jmp_op == 1 || (jmp_op == 2 && cmp));
    why = 0;
    if (valid && fault) begin kind = 1; why = 1; end
    else if (valid && jmp_op == 3) begin
      if (m_mode == 1) kind = 2; else begin kind = 1; why = 3; end
    end
    else if (redirect) begin
      if (bad_target(next_addr)) begin kind = 1; why = 2; end else kind = 3;
    end
    else kind = 0;
    if (!stall) m_flush = 0;
    case (kind)
      1: begin
        m_addr = TV;
        if (m_mode == 1) begin m_mode = 2; m_halt = 1; m_flush = 0; end
        else begin m_mode = 1; m_epc = wb_pc; m_cause = why; m_trap = 1; m_flush = 1; end
      end
      2: begin m_addr = m_epc; m_mode = 0; m_flush = 1; end
      3: begin m_addr = next_addr; m_flush = 1; end
      default: if (!stall) m_addr = m_addr + step_size();
    endcase
  endtask

  // Advance one clock and compare every output against the model.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("addr",  addr,  m_addr);
    chk("flush", flush, m_flush);
    chk("trap",  trap,  m_trap);
    chk("epc",   epc,   m_epc);
    chk("cause", cause, m_cause);
    chk("halt",  halt,  m_halt);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic c, input logic f,
                       input logic [31:0] na, input logic [31:0] pc, input logic st);
    valid = v; jmp_op = op; cmp = c; fault = f; next_addr = na; wb_pc = pc; stall = st;
  endtask

  task automatic idle(input logic st);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, st);
  endtask

  initial begin
    rst_n = 1'b0; ilen16 = 1'b0;
    idle(1'b0);
    @(negedge clk);
    cyc();
    chk("rst_addr", addr, RV);
    chk("rst_halt", halt, 1'b0);
    rst_n = 1'b1;

    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("seq_addr", addr, 32'(4 * i));
      chk("seq_flush", flush, 1'b0);
    end

    drive(1'b1, 2'd1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b1);
    cyc();
    chk("jmp_addr", addr, 32'h100);
    idle(1'b1);
    cyc(); cyc();
    chk("jmp_flush_stall", flush, 1'b1);
    idle(1'b0);
    cyc();
    chk("jmp_flush_clr", flush, 1'b0);
    chk("jmp_seq", addr, 32'h104);

    drive(1'b1, 2'd2, 1'b1, 1'b0, 32'h102, 32'h40, 1'b0);
    cyc();
    chk("mis_addr", addr, TV);
    chk("mis_epc", epc, 32'h40);
    chk("mis_cause", cause, 2'd2);
    chk("mis_trap", trap, 1'b1);
    idle(1'b0);
    cyc();
    chk("trap_pulse_end", trap, 1'b0);
    drive(1'b1, 2'd2, 1'b0, 1'b0, 32'h102, 32'h44, 1'b0);
    cyc();
    chk("nt_addr", addr, TV + 32'd8);
    chk("nt_trap", trap, 1'b0);
    drive(1'b1, 2'd3, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    cyc();
    chk("ret1_addr", addr, 32'h40);

    drive(1'b1, 2'd0, 1'b0, 1'b1, 32'h0, 32'h80, 1'b0);
    cyc();
    chk("flt_epc", epc, 32'h80);
    chk("flt_cause", cause, 2'd1);
    drive(1'b1, 2'd3, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc();
    chk("ret2_addr", addr, 32'h80);
    drive(1'b1, 2'd3, 1'b0, 1'b0, 32'h0, 32'h90, 1'b0);
    cyc();
    chk("illret_cause", cause, 2'd3);
    chk("illret_trap", trap, 1'b1);
    drive(1'b1, 2'd0, 1'b0, 1'b1, 32'h0, 32'h123, 1'b0);
    cyc();
    chk("dbl_halt", halt, 1'b1);
    chk("dbl_epc", epc, 32'h90);
    for (int i = 0; i < 10; i++) begin
      drive(1'(i % 2), 2'(i), 1'b1, 1'(i % 3 == 0), 32'h300, 32'h44, 1'b0);
      cyc();
      chk("halt_addr", addr, TV);
      chk("halt_flush", flush, 1'b0);
    end
    rst_n = 1'b0;
    cyc();
    chk("rst2_addr", addr, RV);
    chk("rst2_halt", halt, 1'b0);
    rst_n = 1'b1;

    drive(1'b1, 2'd1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0);
    cyc();
    idle(1'b0);
    cyc();
    chk("wrap_addr", addr, 32'h0);

`ifdef PC_C_EXT_EN
    drive(1'b1, 2'd1, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    cyc();
    idle(1'b0); ilen16 = 1'b1;
    cyc();
    chk("c_inc", addr, 32'h12);
    ilen16 = 1'b0;
    drive(1'b1, 2'd1, 1'b0, 1'b0, 32'h102, 32'h0, 1'b0);
    cyc();
    chk("c_jmp", addr, 32'h102);
    chk("c_notrap", trap, 1'b0);
`endif

    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      stall     = ($urandom_range(0, 2) == 0);
      valid     = ($urandom_range(0, 1) == 1);
      fault     = ($urandom_range(0, 15) == 0);
      jmp_op    = 2'($urandom_range(0, 3));
      cmp       = 1'($urandom_range(0, 1));
      ilen16    = 1'($urandom_range(0, 1));
      wb_pc     = $urandom;
      next_addr = $urandom;
      if ($urandom_range(0, 3) != 0) next_addr[1:0] = 2'b00;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
